uart_rx_core: RTL
=================

// Module: uart_rx_core
// PURPOSE
//   Asynchronous serial receiver for UART_Project; the receiving end of the Tx link.
//   Samples RxDataIn at mid-bit, deserialises 8N1 LSB-first frames and presents each
//   byte on RxDataOut with a one-cycle RxDone strobe. Bad frames raise RxError instead.
//   BaudRate selects one of two line rates at run time.
// PARAMETERS
//   CLK_FREQ_HZ  10_000_000  system clock frequency
//   BAUD_LO      9600        rate when BaudRate=0 (bit = CLK_FREQ_HZ/BAUD_LO = 1041 clks)
//   BAUD_HI      19200       rate when BaudRate=1 (bit = 520 clks)
//   PARITY_ODD   0           0=even, 1=odd; used only when UART_RX_PARITY_EN is defined
// PORTS
//   Clock      in   1  system clock, rising edge
//   Reset      in   1  asynchronous, active-low reset
//   BaudRate   in   1  rate select (0=BAUD_LO, 1=BAUD_HI)
//   RxDataIn   in   1  serial line; idles high
//   RxDataOut  out  8  last good byte received
//   RxDone     out  1  one-cycle pulse when RxDataOut updates
//   RxError    out  1  one-cycle pulse on framing/parity error
//   RxBusy     out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//   - Reset low: RxDataOut=8'h00, RxDone=0, RxError=0, RxBusy=0, state=IDLE, armed=0.
//     The 2-FF synchroniser resets to 1.
//   - RxDataIn passes through the 2-FF synchroniser (2-clk delay). All logic uses the
//     synchronised value `rxs`.
//   - armed: set when rxs=1 in IDLE; cleared on reset and after a framing error. A start
//     bit is accepted only while armed, so release of Reset mid-frame or a break never
//     decodes as data.
//   - Bit length N = CLK_FREQ_HZ/BAUD_x (integer divide). BaudRate is latched at
//     start detect; changes mid-frame are ignored until IDLE.
//   - Bit counter is 11 bits wide and counts 0..N-1.
//   - FSM states:
//     IDLE:   armed & rxs=0 -> START; clear counter; RxBusy=1.
//     START:  at count=N/2-1 re-sample. rxs=1 -> glitch: IDLE, no error. Else -> DATA
//             with counter cleared; sample points thereafter are every N clks (mid-bit).
//     DATA:   shift rxs into shift[7] (right shift, LSB first); after 8 bits -> PARITY
//             if enabled, else STOP.
//     PARITY: sample p; perr = ^{shift,p} != PARITY_ODD; -> STOP.
//     STOP:   sample. rxs=1 & !perr: RxDataOut<=shift, RxDone=1, -> IDLE.
//             rxs=1 & perr: RxError=1, RxDataOut held, -> IDLE.
//             rxs=0: RxError=1, RxDataOut held, armed=0, -> IDLE.
//   - Latency: RxDone asserts 9.5 bit periods (10.5 with parity) + 2 clks after the
//     falling edge of the start bit, i.e. at mid-stop-bit. A new start bit is accepted
//     from the next clock, so back-to-back frames with a single stop bit are received.
//   - RxDone and RxError are never high together. Each is exactly 1 clk wide.
//   - Reset asserted mid-frame aborts immediately. No RxDone/RxError is emitted for the
//     aborted frame.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:   frame is 8 data + 1 parity (PARITY_ODD) + 1 stop;
//                                a parity mismatch causes an RxError pulse.
//   UART_RX_PARITY_EN undefined: 8N1; PARITY state and perr logic are not built, and
//                                perr is treated as 0.
// TESTING
//   1 Reset low 1us, line high, BaudRate=0; send 8'h33 8N1 at 104167ns/bit
//     -> RxDataOut=8'h33, one RxDone pulse ~989.6us after start edge, RxError=0.
//   2 BaudRate=1; send 8'hA5 then 8'h5A back-to-back at 52083ns/bit
//     -> two RxDone pulses, values A5 then 5A in order.
//   3 Low glitch of 20us (<half bit) at BaudRate=0 -> RxBusy pulses, then IDLE;
//     no RxDone/RxError; a following 8'hFF frame is received correctly.
//   4 Send 8'hC3 with stop bit=0, line held low 2 bit periods, then high
//     -> RxError pulse, RxDataOut keeps previous value; no decode until the line has
//        returned high; next 8'h3C frame is received OK.
//   5 Pull Reset low during data bit 4 of 8'h81, release, finish the frame
//     -> outputs 0 during reset; no RxDone for the frame; next 8'h7E frame is good.
//   6 (UART_RX_PARITY_EN, PARITY_ODD=0) 8'h07 with parity bit 1 -> RxDone, data 07;
//     same byte with parity bit 0 -> RxError, RxDataOut unchanged.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 (optionally 8-parity-1) UART receiver with mid-bit sampling and run-time rate select.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even) to each frame.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned BAUD_LO     = 9600,
  parameter int unsigned BAUD_HI     = 19200,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BaudRate,
  input  logic       RxDataIn,
  output logic [7:0] RxDataOut,
  output logic       RxDone,
  output logic       RxError,
  output logic       RxBusy
);

  localparam logic [10:0] N_LO = 11'(CLK_FREQ_HZ / BAUD_LO);
  localparam logic [10:0] N_HI = 11'(CLK_FREQ_HZ / BAUD_HI);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_sync1, r_sync2;
  logic [1:0]  r_sync_vld;
  logic        r_armed;
  logic        r_baud;
  logic [10:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bitn;
  logic [7:0]  r_shift;
  logic        w_rxs;
  logic [10:0] w_n, w_half;
  logic        w_bit_end;
  logic        w_start, w_shift_en, w_done, w_err, w_disarm, w_perr_ld, w_perr;

  assign w_rxs     = r_sync2;
  assign w_n       = r_baud ? N_HI : N_LO;
  assign w_half    = (w_n >> 1) - 11'd1;
  assign w_bit_end = (r_cnt == w_n - 11'd1);
  assign RxBusy    = (r_state != S_IDLE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 11'd1;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_disarm    = 1'b0;
    w_perr_ld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_armed && !w_rxs) begin
          w_state_nxt = S_START;
          w_start     = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == w_half) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt  = '0;
          w_shift_en = 1'b1;
          if (r_bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_perr_ld   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (!w_rxs) begin
            w_err    = 1'b1;
            w_disarm = 1'b1;
          end else if (w_perr) begin
            w_err = 1'b1;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // r_sync_vld holds off arming until the synchroniser carries the real line,
  // since its reset value of 1 would otherwise arm mid-frame after reset release.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync_vld <= '0;
      r_armed    <= 1'b0;
      r_baud     <= 1'b0;
      r_cnt      <= '0;
      r_bitn     <= '0;
      r_shift    <= '0;
      RxDataOut  <= '0;
      RxDone     <= 1'b0;
      RxError    <= 1'b0;
    end else begin
      r_sync1    <= RxDataIn;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_cnt      <= w_cnt_nxt;
      RxDone     <= w_done;
      RxError    <= w_err;
      if (w_start) begin
        r_baud <= BaudRate;
        r_bitn <= '0;
      end
      if (w_shift_en) begin
        r_shift <= {w_rxs, r_shift[7:1]};
        r_bitn  <= r_bitn + 3'd1;
      end
      if (w_done) RxDataOut <= r_shift;
      if (w_disarm)
        r_armed <= 1'b0;
      else if (r_state == S_IDLE && w_rxs && r_sync_vld[1])
        r_armed <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_perr;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)         r_perr <= 1'b0;
    else if (w_start)   r_perr <= 1'b0;
    else if (w_perr_ld) r_perr <= ((^{r_shift, w_rxs}) != 1'(PARITY_ODD));
  end
  assign w_perr = r_perr;
`else
  logic w_unused_cfg;
  assign w_perr       = 1'b0;
  assign w_unused_cfg = 1'(PARITY_ODD) ^ w_perr_ld;
`endif

endmodule
